// File: rtl/rf_mp_pkg.sv
// Shared definitions for the multi-port register file: widths, the
// hardwired-zero register address and small elaboration-time helpers.
package rf_mp_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG0_ADDR    = 0;

  // Bounded loop so the function stays usable in constant expressions.
  function automatic int rf_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Width of a port-index field; never zero, even for a single write port.
  function automatic int rf_idx_w(input int n);
    return (n > 1) ? rf_clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_mp_if.sv
// Read, write, allocate and flush signals between decode/writeback and rf_mp.
interface rf_mp_if
  import rf_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
) ();

  localparam int AW = rf_clog2(NREGS);

  logic [NREAD*AW-1:0]    i_raddr;
  logic [NREAD*XLEN-1:0]  o_rdata;
  logic [NREAD-1:0]       o_rbusy;
  logic [NWRITE-1:0]      i_wen;
  logic [NWRITE*AW-1:0]   i_waddr;
  logic [NWRITE*XLEN-1:0] i_wdata;
  logic                   i_alloc_en;
  logic [AW-1:0]          i_alloc_addr;
  logic                   i_flush;
  logic [NREGS-1:0]       o_busy_vec;

  modport master (
    output i_raddr, i_wen, i_waddr, i_wdata, i_alloc_en, i_alloc_addr, i_flush,
    input  o_rdata, o_rbusy, o_busy_vec
  );

  modport slave (
    input  i_raddr, i_wen, i_waddr, i_wdata, i_alloc_en, i_alloc_addr, i_flush,
    output o_rdata, o_rbusy, o_busy_vec
  );

endinterface

// File: rtl/rf_mp_wr_sel.sv
// Resolves which write port (if any) targets a given address this cycle;
// the highest-indexed enabled port wins, and register 0 never hits.
module rf_wr_sel
  import rf_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int AW     = 5,
  parameter int NWRITE = 1,
  parameter int PW     = rf_idx_w(NWRITE)
) (
  input  logic [AW-1:0]          addr_i,
  input  logic [NWRITE-1:0]      wen_i,
  input  logic [NWRITE*AW-1:0]   waddr_i,
  input  logic [NWRITE*XLEN-1:0] wdata_i,
  output logic                   hit_o,
  output logic [XLEN-1:0]        data_o,
  output logic [PW-1:0]          port_o
);

  // NOTE: every output gets a default before the loop; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    port_o = '0;
    for (int p = 0; p < NWRITE; p++) begin
      if (wen_i[p] && (waddr_i[p*AW +: AW] == addr_i) && (addr_i != AW'(REG0_ADDR))) begin
        hit_o  = 1'b1;
        data_o = wdata_i[p*XLEN +: XLEN];
        port_o = PW'(p);
      end
    end
  end

endmodule

// File: rtl/rf_mp.sv
// Parametrised multi-port register file with per-register busy scoreboard,
// optional same-cycle write-to-read bypass and hardwired-zero register 0.
module rf_mp
  import rf_mp_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int NREGS     = 32,
  parameter int NREAD     = 2,
  parameter int NWRITE    = 1,
  parameter int BYPASS_EN = 1
) (
  input logic   i_clk,
  input logic   i_rst,
  rf_mp_if.slave bus
);

  localparam int AW = rf_clog2(NREGS);
  localparam int PW = rf_idx_w(NWRITE);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  assign mem_d[0]  = '0;
  assign busy_d[0] = 1'b0;

  // Per-register next state; flush beats allocation, allocation beats a write.
  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    logic            whit;
    logic [XLEN-1:0] wdat;
    logic [PW-1:0]   wport;
    logic            unused_wport;

    rf_wr_sel #(.XLEN(XLEN), .AW(AW), .NWRITE(NWRITE), .PW(PW)) u_wsel (
      .addr_i  (AW'(r)),
      .wen_i   (bus.i_wen),
      .waddr_i (bus.i_waddr),
      .wdata_i (bus.i_wdata),
      .hit_o   (whit),
      .data_o  (wdat),
      .port_o  (wport)
    );

    assign unused_wport = ^wport;
    assign mem_d[r]     = whit ? wdat : mem_q[r];
    assign busy_d[r]    = bus.i_flush                                     ? 1'b0 :
                          (bus.i_alloc_en && bus.i_alloc_addr == AW'(r)) ? 1'b1 :
                          whit                                            ? 1'b0 :
                                                                            busy_q[r];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  // NOTE: the storage array is reset on purpose: every address must read as
  // zero right after reset, so this array cannot map onto a plain RAM macro.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q <= '0;
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int r = 0; r < NREGS; r++) mem_q[r] <= mem_d[r];
    end
  end

  assign bus.o_busy_vec = busy_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit;
    logic            byp;
    logic [XLEN-1:0] bdata;
    logic [PW-1:0]   bport;
    logic            unused_rport;

    assign ra = bus.i_raddr[k*AW +: AW];

    rf_wr_sel #(.XLEN(XLEN), .AW(AW), .NWRITE(NWRITE), .PW(PW)) u_rsel (
      .addr_i  (ra),
      .wen_i   (bus.i_wen),
      .waddr_i (bus.i_waddr),
      .wdata_i (bus.i_wdata),
      .hit_o   (hit),
      .data_o  (bdata),
      .port_o  (bport)
    );

    // Same-cycle allocation is deliberately ignored here: only a write clears busy.
    assign byp                        = (BYPASS_EN != 0) && hit;
    assign unused_rport               = ^bport;
    assign bus.o_rdata[k*XLEN +: XLEN] = byp ? bdata : mem_q[ra];
    assign bus.o_rbusy[k]             = byp ? 1'b0 : busy_q[ra];
  end

endmodule
